// File: rtl/pong_pkg.sv
// pong_pkg: types and screen constants shared by the pong datapath
// (physics, ball_renderer).
//   X_MAX / Y_MAX    screen size in pixels
//   colour_t         3-bit adapter colour
//   coord_x_t/_y_t   on-screen coordinate widths
//   render_state_t   ball_renderer FSM states
package pong_pkg;

  localparam int X_MAX = 320;
  localparam int Y_MAX = 240;

  typedef logic [2:0] colour_t;
  typedef logic [8:0] coord_x_t;
  typedef logic [7:0] coord_y_t;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_ERASE,
    ST_DRAW,
    ST_DONE
  } render_state_t;

endpackage

// File: rtl/pixel_scan.sv
// pixel_scan: 2-D row-major pixel counter.
//   clock, reset      clock / async active-high reset
//   start             hold offsets at (0,0)
//   step              advance one pixel (x inner, y outer), wrapping after the last
//   base_x, base_y    top-left corner of the scanned rectangle
//   width, height     rectangle size in pixels
//   cur_x, cur_y      base + offset, one bit wider than the screen coordinate
//                     so off-screen pixels never wrap back on screen
//   last              current pixel is the bottom-right one
module pixel_scan
  import pong_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       step,
  input  coord_x_t   base_x,
  input  coord_y_t   base_y,
  input  logic [8:0] width,
  input  logic [7:0] height,
  output logic [9:0] cur_x,
  output logic [8:0] cur_y,
  output logic       last
);

  logic [8:0] off_x;
  logic [7:0] off_y;
  logic       last_col;
  logic       last_row;

  assign last_col = (off_x == width - 9'd1);
  assign last_row = (off_y == height - 8'd1);
  assign last     = last_col && last_row;

  assign cur_x = {1'b0, base_x} + {1'b0, off_x};
  assign cur_y = {1'b0, base_y} + {1'b0, off_y};

  // Wrapping to (0,0) after the last pixel lets back-to-back scans
  // (ERASE then DRAW) start cleanly without an explicit restart.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      off_x <= '0;
      off_y <= '0;
    end else if (start) begin
      off_x <= '0;
      off_y <= '0;
    end else if (step) begin
      if (last_col) begin
        off_x <= '0;
        off_y <= last_row ? 8'd0 : off_y + 8'd1;
      end else begin
        off_x <= off_x + 9'd1;
      end
    end
  end

endmodule

// File: rtl/ball_renderer.sv
// ball_renderer: draws the ball square into the VGA frame buffer, one pixel
// per clock. Clears the screen after reset, then for each update erases the
// previous square and draws the new one.
//   clock, reset        clock / async active-high reset
//   x_in, y_in, update  new ball top-left position and its one-cycle strobe
//   busy                clearing, erasing or drawing
//   done                one-cycle pulse when a draw completes
//   vga_x, vga_y,
//   vga_colour, plot    pixel write port to the VGA adapter
//
// state    | meaning
// CLEAR    | sweep whole screen in background colour
// IDLE     | wait for update
// ERASE    | paint old square in background colour
// DRAW     | paint new square in ball colour
// DONE     | pulse done, new -> old, start pending update if any
module ball_renderer
  import pong_pkg::*;
#(
  parameter int      BALL_SIZE   = 4,
  parameter int      X_MAX       = pong_pkg::X_MAX,
  parameter int      Y_MAX       = pong_pkg::Y_MAX,
  parameter colour_t BG_COLOUR   = 3'b000,
  parameter colour_t BALL_COLOUR = 3'b111
) (
  input  logic     clock,
  input  logic     reset,
  input  coord_x_t x_in,
  input  coord_y_t y_in,
  input  logic     update,
  output logic     busy,
  output logic     done,
  output coord_x_t vga_x,
  output coord_y_t vga_y,
  output colour_t  vga_colour,
  output logic     plot
);

  localparam logic [8:0] CLR_W  = X_MAX[8:0];
  localparam logic [7:0] CLR_H  = Y_MAX[7:0];
  localparam logic [8:0] BALL_W = BALL_SIZE[8:0];
  localparam logic [7:0] BALL_H = BALL_SIZE[7:0];
  localparam logic [9:0] X_LIM  = X_MAX[9:0];
  localparam logic [8:0] Y_LIM  = Y_MAX[8:0];

  render_state_t state;
  coord_x_t      new_x, old_x, pend_x;
  coord_y_t      new_y, old_y, pend_y;
  logic          old_valid, pend_valid;

  logic          scanning;
  coord_x_t      base_x;
  coord_y_t      base_y;
  logic [8:0]    scan_w;
  logic [7:0]    scan_h;
  logic [9:0]    cur_x;
  logic [8:0]    cur_y;
  logic          scan_last;

  // An update arriving on the very cycle a pending slot is consumed wins
  // over the older pending value.
  logic          take;
  coord_x_t      take_x;
  coord_y_t      take_y;

  assign scanning = (state == ST_CLEAR) || (state == ST_ERASE) || (state == ST_DRAW);
  assign take     = update || pend_valid;
  assign take_x   = update ? x_in : pend_x;
  assign take_y   = update ? y_in : pend_y;

  always_comb begin
    base_x = '0;
    base_y = '0;
    scan_w = BALL_W;
    scan_h = BALL_H;
    case (state)
      ST_CLEAR: begin
        scan_w = CLR_W;
        scan_h = CLR_H;
      end
      ST_ERASE: begin
        base_x = old_x;
        base_y = old_y;
      end
      ST_DRAW: begin
        base_x = new_x;
        base_y = new_y;
      end
      default: ;
    endcase
  end

  pixel_scan u_scan (
    .clock  (clock),
    .reset  (reset),
    .start  (!scanning),
    .step   (scanning),
    .base_x (base_x),
    .base_y (base_y),
    .width  (scan_w),
    .height (scan_h),
    .cur_x  (cur_x),
    .cur_y  (cur_y),
    .last   (scan_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_CLEAR;
      busy       <= 1'b1;
      done       <= 1'b0;
      plot       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= BG_COLOUR;
      new_x      <= '0;
      new_y      <= '0;
      old_x      <= '0;
      old_y      <= '0;
      pend_x     <= '0;
      pend_y     <= '0;
      old_valid  <= 1'b0;
      pend_valid <= 1'b0;
    end else begin
      // busy follows the state one cycle late so it spans exactly the
      // cycles on which registered pixels are presented.
      busy <= (state != ST_IDLE);
      done <= (state == ST_DONE);
      plot <= scanning && (cur_x < X_LIM) && (cur_y < Y_LIM);
      if (scanning) begin
        vga_x      <= cur_x[8:0];
        vga_y      <= cur_y[7:0];
        vga_colour <= (state == ST_DRAW) ? BALL_COLOUR : BG_COLOUR;
      end

      if (update && state != ST_IDLE) begin
        pend_x     <= x_in;
        pend_y     <= y_in;
        pend_valid <= 1'b1;
      end

      case (state)
        ST_CLEAR: begin
          if (scan_last) begin
            if (take) begin
              new_x      <= take_x;
              new_y      <= take_y;
              pend_valid <= 1'b0;
              state      <= ST_DRAW;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_IDLE: begin
          if (update) begin
            new_x <= x_in;
            new_y <= y_in;
            state <= old_valid ? ST_ERASE : ST_DRAW;
          end
        end
        ST_ERASE: if (scan_last) state <= ST_DRAW;
        ST_DRAW:  if (scan_last) state <= ST_DONE;
        ST_DONE: begin
          old_x     <= new_x;
          old_y     <= new_y;
          old_valid <= 1'b1;
          if (take) begin
            new_x      <= take_x;
            new_y      <= take_y;
            pend_valid <= 1'b0;
            state      <= ST_ERASE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_renderer.sv
// tb_ball_renderer: directed self-checking bench for ball_renderer, run on a
// reduced 128x64 screen so each clear is short.
module tb_ball_renderer;

  localparam int XM = 128;
  localparam int YM = 64;
  localparam int BS = 4;
  localparam int NCAP = 128;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       update = 1'b0;
  logic [8:0] x_in = '0;
  logic [7:0] y_in = '0;
  logic       busy, done, plot;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;

  always #5 clock = ~clock;

  ball_renderer #(
    .BALL_SIZE   (BS),
    .X_MAX       (XM),
    .Y_MAX       (YM),
    .BG_COLOUR   (3'b000),
    .BALL_COLOUR (3'b111)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .x_in       (x_in),
    .y_in       (y_in),
    .update     (update),
    .busy       (busy),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // per-cycle capture, index = edges after the first update edge (edge 0)
  bit cap_plot [0:NCAP-1];
  bit cap_done [0:NCAP-1];
  bit cap_busy [0:NCAP-1];
  int cap_x    [0:NCAP-1];
  int cap_y    [0:NCAP-1];
  int cap_col  [0:NCAP-1];

  int sched_n;
  int sched_c [0:7];
  int sched_x [0:7];
  int sched_y [0:7];

  bit seen [0:XM*YM-1];

  // caller is #1 after a posedge
  task automatic capture(input int n);
    for (int k = 0; k <= n; k++) begin
      update = 1'b0;
      for (int j = 0; j < sched_n; j++)
        if (sched_c[j] == k) begin
          update = 1'b1;
          x_in   = 9'(sched_x[j]);
          y_in   = 8'(sched_y[j]);
        end
      @(posedge clock);
      #1;
      update      = 1'b0;
      cap_plot[k] = plot;
      cap_done[k] = done;
      cap_busy[k] = busy;
      cap_x[k]    = int'(vga_x);
      cap_y[k]    = int'(vga_y);
      cap_col[k]  = int'(vga_colour);
    end
  endtask

  // expected square scan starting at capture cycle s
  function automatic int scan_err(input int s, input int bx, input int by, input int col);
    int e = 0;
    for (int i = 0; i < BS * BS; i++) begin
      int px = bx + i % BS;
      int py = by + i / BS;
      bit ep = (px < XM) && (py < YM);
      if (cap_plot[s+i] != ep) e++;
      else if (ep && (cap_x[s+i] != px || cap_y[s+i] != py || cap_col[s+i] != col)) e++;
    end
    return e;
  endfunction

  function automatic int first_done(input int n);
    for (int k = 1; k <= n; k++) if (cap_done[k]) return k;
    return -1;
  endfunction

  function automatic int count_plots(input int a, input int b);
    int c = 0;
    for (int k = a; k <= b; k++) if (cap_plot[k]) c++;
    return c;
  endfunction

  // caller releases reset on a negedge just before calling
  task automatic wait_clear(input string tag);
    int plots = 0, busy_c = 0, bad = 0, dups = 0, missing = 0;
    for (int i = 0; i < XM * YM; i++) seen[i] = 1'b0;
    for (int c = 0; c < XM * YM + 100; c++) begin
      @(posedge clock);
      #1;
      if (busy) busy_c++;
      if (plot) begin
        plots++;
        if (vga_colour != 3'b000 || vga_x >= XM || vga_y >= YM) bad++;
        else if (seen[int'(vga_y) * XM + int'(vga_x)]) dups++;
        else seen[int'(vga_y) * XM + int'(vga_x)] = 1'b1;
      end
      if (!busy) break;
    end
    for (int i = 0; i < XM * YM; i++) if (!seen[i]) missing++;
    chk({tag, " busy_fell"}, int'(busy), 0);
    chk({tag, " plots"}, plots, XM * YM);
    chk({tag, " busy_cycles"}, busy_c, XM * YM);
    chk({tag, " bad_or_dup"}, bad + dups, 0);
    chk({tag, " missing"}, missing, 0);
  endtask

  typedef struct {
    int x;
    int y;
    bit has_erase;
    int ox;
    int oy;
    int exp_done;
    int exp_plots;
  } vec_t;

  vec_t vecs [0:3];

  initial begin
    vecs[0] = '{x: 100, y: 50, has_erase: 0, ox: 0,   oy: 0,  exp_done: 17, exp_plots: 16};
    vecs[1] = '{x: 104, y: 50, has_erase: 1, ox: 100, oy: 50, exp_done: 33, exp_plots: 32};
    vecs[2] = '{x: 126, y: 62, has_erase: 1, ox: 104, oy: 50, exp_done: 33, exp_plots: 20};
    vecs[3] = '{x: 0,   y: 0,  has_erase: 1, ox: 126, oy: 62, exp_done: 33, exp_plots: 20};

    // reset values
    repeat (3) @(posedge clock);
    #1;
    chk("rst busy", int'(busy), 1);
    chk("rst done", int'(done), 0);
    chk("rst plot", int'(plot), 0);
    chk("rst vga_x", int'(vga_x), 0);
    chk("rst vga_y", int'(vga_y), 0);
    chk("rst colour", int'(vga_colour), 0);

    // reset in the middle of a clear
    @(negedge clock) reset = 1'b0;
    repeat (50) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    #1;
    chk("midclear plot", int'(plot), 0);
    chk("midclear busy", int'(busy), 1);
    @(negedge clock) reset = 1'b0;
    wait_clear("clear1");

    // table: first draw, move, clip, move off clipped square
    for (int v = 0; v < 4; v++) begin
      int d;
      int e;
      sched_n = 1;
      sched_c[0] = 0;
      sched_x[0] = vecs[v].x;
      sched_y[0] = vecs[v].y;
      capture(40);
      d = first_done(40);
      e = vecs[v].has_erase ? scan_err(1, vecs[v].ox, vecs[v].oy, 0) : 0;
      e += scan_err(vecs[v].has_erase ? 17 : 1, vecs[v].x, vecs[v].y, 7);
      chk($sformatf("vec%0d done_cycle", v), d, vecs[v].exp_done);
      chk($sformatf("vec%0d pixel_errs", v), e, 0);
      chk($sformatf("vec%0d plot_count", v), count_plots(1, 40), vecs[v].exp_plots);
      chk($sformatf("vec%0d busy_at_done", v), int'(cap_busy[vecs[v].exp_done]), 1);
      chk($sformatf("vec%0d busy_after", v), int'(cap_busy[vecs[v].exp_done + 1]), 0);
    end

    // back-to-back: A,B,C during the draw of X, then D on the DONE cycle
    sched_n = 5;
    sched_c[0] = 0;  sched_x[0] = 10; sched_y[0] = 10;
    sched_c[1] = 20; sched_x[1] = 20; sched_y[1] = 20;
    sched_c[2] = 22; sched_x[2] = 30; sched_y[2] = 30;
    sched_c[3] = 24; sched_x[3] = 40; sched_y[3] = 40;
    sched_c[4] = 66; sched_x[4] = 50; sched_y[4] = 50;
    capture(105);
    chk("b2b first_done", first_done(105), 33);
    chk("b2b done66", int'(cap_done[66]), 1);
    chk("b2b done99", int'(cap_done[99]), 1);
    chk("b2b erase0", scan_err(1, 0, 0, 0), 0);
    chk("b2b drawX", scan_err(17, 10, 10, 7), 0);
    chk("b2b eraseX", scan_err(34, 10, 10, 0), 0);
    chk("b2b drawC", scan_err(50, 40, 40, 7), 0);
    chk("b2b eraseC", scan_err(67, 40, 40, 0), 0);
    chk("b2b drawD", scan_err(83, 50, 50, 7), 0);
    chk("b2b plots", count_plots(1, 105), 96);
    chk("b2b idle", int'(cap_busy[100]), 0);

    // reset during DRAW
    sched_n = 1;
    sched_c[0] = 0; sched_x[0] = 60; sched_y[0] = 20;
    capture(20);
    chk("pre-reset drawing", int'(plot), 1);
    #2 reset = 1'b1;
    #1;
    chk("rstdraw plot", int'(plot), 0);
    chk("rstdraw busy", int'(busy), 1);
    chk("rstdraw done", int'(done), 0);
    @(negedge clock) reset = 1'b0;
    wait_clear("clear2");

    sched_n = 1;
    sched_c[0] = 0; sched_x[0] = 5; sched_y[0] = 5;
    capture(40);
    chk("post-reset done_cycle", first_done(40), 17);
    chk("post-reset draw", scan_err(1, 5, 5, 7), 0);
    chk("post-reset plots", count_plots(1, 40), 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ball_renderer.md
# ball_renderer

Downstream of `physics` in the pong datapath. Consumes the ball coordinate `physics` produces and draws it into the VGA adapter's frame buffer one pixel per clock. Each move is drawn by erasing the previous ball square in the background colour, then drawing the new square in the ball colour. After reset it clears the whole screen before accepting any draw.

## Interface
- `BALL_SIZE`, 4: side length of the square ball in pixels (1–16)
- `X_MAX`, 320: screen width; legal x is 0..X_MAX-1
- `Y_MAX`, 240: screen height; legal y is 0..Y_MAX-1
- `BG_COLOUR`, 3'b000: erase/clear colour
- `BALL_COLOUR`, 3'b111: ball colour

Ports:
- `clock`  in  1: single clock; every register is on posedge `clock`
- `reset`  in  1: asynchronous, active-high; forces CLEAR entry state and all outputs to reset values
- `x_in`  in  9: ball top-left x, from `physics` `x`
- `y_in`  in  8: ball top-left y, from `physics` `y`
- `update`  in  1: one-cycle pulse meaning `x_in`/`y_in` hold a new position to draw
- `busy`  out  1: high while clearing, erasing or drawing
- `done`  out  1: one-cycle pulse when a draw completes
- `vga_x`  out  9: pixel x to the adapter
- `vga_y`  out  8: pixel y to the adapter
- `vga_colour`  out  3: pixel colour to the adapter
- `plot`  out  1: write-enable to the adapter; the adapter writes the pixel on any cycle `plot`=1

## Operation
- States: CLEAR → IDLE → ERASE → DRAW → DONE → IDLE.
- **CLEAR**
  - Entered asynchronously on reset.
  - Sweeps x 0..X_MAX-1 (inner loop) and y 0..Y_MAX-1 (outer loop), writing `BG_COLOUR`.
  - Then goes to IDLE.
- **IDLE**
  - `busy`=0.
  - On `update`, latch `x_in`/`y_in` into the new-position register.
  - If the old-position valid flag is set, go to ERASE; otherwise skip straight to DRAW.
- **ERASE**
  - Scans the old-position square row-major, writing `BG_COLOUR`.
  - BALL_SIZE² cycles, then DRAW.
- **DRAW**
  - Scans the new-position square row-major, writing `BALL_COLOUR`.
  - BALL_SIZE² cycles, then DONE.
- **DONE**
  - `done`=1 for one cycle.
  - Copies new position to old position and sets the old-position valid flag.
  - Next state: IDLE, or ERASE directly if an update is pending.
- **Pending update**
  - `update` while `busy`=1 loads a one-deep pending register (x, y, flag).
  - Last write wins; earlier pending values are dropped silently.
  - Pending updates are consumed at DONE, or at the end of CLEAR. After CLEAR, go to DRAW, because the old position is not valid yet.
- **Clipping**
  - A square pixel with x ≥ X_MAX or y ≥ Y_MAX is still stepped (the cycle count does not change) but drives `plot`=0.
  - Offsets are added at 10-bit (x) and 9-bit (y) width, so the compare sees no wrap-around.
- **Update in IDLE and DONE together:** an `update` arriving in the same cycle as a DONE-to-IDLE transition is treated as pending. It is not lost.
- **Reset mid-operation:** aborts immediately and clears the old-position valid flag and the pending flag. Restarts CLEAR.

## Timing
- Reset values:
  - `busy`=1 (CLEAR)
  - `done`=0, `plot`=0
  - `vga_x`=0, `vga_y`=0, `vga_colour`=`BG_COLOUR`
- Outputs are registered. The first pixel of a scan appears the cycle after state entry.
- CLEAR takes X_MAX·Y_MAX pixel cycles; 76800 with the defaults.
- With BALL_SIZE=4 and `update` sampled at edge 0 in IDLE (old position valid):
  - erase pixels at cycles 1–16
  - draw pixels at cycles 17–32
  - `done` at cycle 33
  - `busy` falls at cycle 34
- First draw after CLEAR (no erase): `done` BALL_SIZE²+1 cycles after the `update` edge.
- `plot` is high only in CLEAR/ERASE/DRAW and only for unclipped pixels.

## Structure
- `pong_pkg` (shared with `physics`) holds:
  - `X_MAX`, `Y_MAX`
  - `colour_t` (3-bit)
  - `coord_x_t` (9-bit), `coord_y_t` (8-bit)
  - the `render_state_t` enum
- One sub-module, `pixel_scan`, a 2-D counter:
  - inputs: `start`, base x/y, width, height
  - outputs: current x/y, `last`
  - Reused for CLEAR (base 0, X_MAX×Y_MAX) and for ERASE/DRAW (BALL_SIZE×BALL_SIZE).

## Test plan
- **Reset clear:** assert `reset` mid-run, then release.
  - Required: `busy`=1 for exactly 76800 plotted cycles.
  - Every (x,y) is written once with colour 000, then `busy`=0.
- **First draw:** `update` with x=100, y=50 after CLEAR.
  - Required: 16 plots at (100..103, 50..53) with colour 111, no erase plots.
  - `done` at cycle 17.
- **Move:** then `update` with x=104, y=50.
  - Required: 16 plots of colour 000 at the old square, then 16 plots of colour 111 at the new square.
  - `done` at cycle 33.
- **Clipping:** `update` with x=318, y=238.
  - Required: only 4 plots (318..319, 238..239) have `plot`=1.
  - `done` is still at cycle 17 (first draw) or 33 (with erase).
- **Back-to-back updates:** three `update` pulses (A, B, C) while busy with a draw.
  - Required: only C is drawn next, and its erase targets the square just drawn.
- **Reset during DRAW:** assert `reset` while in DRAW.
  - Required: `plot` drops at once and CLEAR restarts.
  - The next `update` produces no erase plots.
